// File: rtl/traffic_light_monitor.sv
// Two-direction traffic light checker: encoding, conflict, sequencing and main-road cycle count.
// Yellow duration checks are compiled in only when TL_MON_YELLOW_TIMING_EN is defined.
module traffic_light_monitor #(
   parameter int YELLOW_MIN = 2,
   parameter int YELLOW_MAX = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       light_main,
   input  logic [2:0]       light_cross,
   input  logic             clr_fault,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] main_cycles
);

   typedef enum logic [2:0] {
      ST_UNPRIMED,
      ST_RED,
      ST_GREEN,
      ST_YELLOW,
      ST_INVALID
   } dir_state_e;

   localparam logic [2:0] LAMP_RED     = 3'b100;
   localparam logic [2:0] LAMP_YELLOW  = 3'b010;
   localparam logic [2:0] LAMP_GREEN   = 3'b001;

   localparam logic [2:0] F_NONE       = 3'd0;
   localparam logic [2:0] F_INVALID    = 3'd1;
   localparam logic [2:0] F_CONFLICT   = 3'd2;
   localparam logic [2:0] F_TRANSITION = 3'd3;

   // Index 0 is the main road, index 1 the cross road.
   logic [2:0]       lamp  [2];
   dir_state_e       trk_q [2];
   dir_state_e       trk_d [2];
   logic             primed_q;
   logic             fault_q;
   logic [2:0]       code_q;
   logic [CNT_W-1:0] cycles_q;
   logic [2:0]       cand;
   logic             any_invalid;
   logic             trans_bad;
   logic             conflict;
   logic             main_r2g;

   assign lamp[0] = light_main;
   assign lamp[1] = light_cross;

`ifdef TL_MON_YELLOW_TIMING_EN
   localparam logic [2:0]      F_YEL_SHORT = 3'd4;
   localparam logic [2:0]      F_YEL_LONG  = 3'd5;
   localparam int              YC_W        = $clog2(YELLOW_MAX + 2);
   localparam logic [YC_W-1:0] Y_MIN_C     = YC_W'(YELLOW_MIN);
   localparam logic [YC_W-1:0] Y_MAX_C     = YC_W'(YELLOW_MAX);
   localparam logic [YC_W-1:0] Y_SAT_C     = YC_W'(YELLOW_MAX + 1);

   logic [YC_W-1:0] ycnt_q [2];
   logic [YC_W-1:0] ycnt_d [2];
   logic            yel_short;
   logic            yel_long;
`endif

   function automatic dir_state_e decode(input logic [2:0] l);
      case (l)
         LAMP_RED:    return ST_RED;
         LAMP_YELLOW: return ST_YELLOW;
         LAMP_GREEN:  return ST_GREEN;
         default:     return ST_INVALID;
      endcase
   endfunction

   function automatic logic legal_step(input dir_state_e p, input dir_state_e c);
      return (p == c)
          || (p == ST_RED    && c == ST_GREEN)
          || (p == ST_GREEN  && c == ST_YELLOW)
          || (p == ST_YELLOW && c == ST_RED);
   endfunction

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_q[0] <= ST_UNPRIMED;
         trk_q[1] <= ST_UNPRIMED;
         primed_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= F_NONE;
         cycles_q <= '0;
      end else begin
         trk_q[0] <= trk_d[0];
         trk_q[1] <= trk_d[1];
         primed_q <= 1'b1;
         if (main_r2g) cycles_q <= cycles_q + CNT_W'(1);
         // A clear pulse still lets a fault seen in the same sample win.
         if (clr_fault) begin
            fault_q <= (cand != F_NONE);
            code_q  <= cand;
         end else if (!fault_q && cand != F_NONE) begin
            fault_q <= 1'b1;
            code_q  <= cand;
         end
      end
   end

`ifdef TL_MON_YELLOW_TIMING_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ycnt_q[0] <= '0;
         ycnt_q[1] <= '0;
      end else begin
         ycnt_q[0] <= ycnt_d[0];
         ycnt_q[1] <= ycnt_d[1];
      end
   end
`endif

   // Next state: each tracker simply records the class of the current sample.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         trk_d[d] = decode(lamp[d]);
`ifdef TL_MON_YELLOW_TIMING_EN
         // NOTE: every path assigns the counter, so no latch is inferred.
         ycnt_d[d] = '0;
         if (trk_d[d] == ST_YELLOW) begin
            if (trk_q[d] != ST_YELLOW)  ycnt_d[d] = YC_W'(1);
            else if (ycnt_q[d] == Y_SAT_C) ycnt_d[d] = ycnt_q[d];
            else                         ycnt_d[d] = ycnt_q[d] + YC_W'(1);
         end
`endif
      end
   end

   // Outputs of the trackers: candidate fault and the main-road cycle event.
   always_comb begin
      any_invalid = 1'b0;
      trans_bad   = 1'b0;
`ifdef TL_MON_YELLOW_TIMING_EN
      yel_short   = 1'b0;
      yel_long    = 1'b0;
`endif
      for (int d = 0; d < 2; d++) begin
         if (trk_d[d] == ST_INVALID) any_invalid = 1'b1;
         if (primed_q && trk_q[d] != ST_INVALID && trk_d[d] != ST_INVALID
             && !legal_step(trk_q[d], trk_d[d]))
            trans_bad = 1'b1;
`ifdef TL_MON_YELLOW_TIMING_EN
         if (trk_q[d] == ST_YELLOW && trk_d[d] == ST_RED && ycnt_q[d] < Y_MIN_C)
            yel_short = 1'b1;
         if (trk_q[d] == ST_YELLOW && trk_d[d] == ST_YELLOW && ycnt_q[d] == Y_MAX_C)
            yel_long = 1'b1;
`endif
      end
      conflict = (light_main != LAMP_RED) && (light_cross != LAMP_RED);
      main_r2g = primed_q && trk_q[0] == ST_RED && trk_d[0] == ST_GREEN;

      cand = F_NONE;
      if (any_invalid)    cand = F_INVALID;
      else if (conflict)  cand = F_CONFLICT;
      else if (trans_bad) cand = F_TRANSITION;
`ifdef TL_MON_YELLOW_TIMING_EN
      else if (yel_short) cand = F_YEL_SHORT;
      else if (yel_long)  cand = F_YEL_LONG;
`endif
   end

   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign main_cycles = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios plus random lamp walks,
// checked against a lamp-history reference model (honours TL_MON_YELLOW_TIMING_EN).
module tb_traffic_light_monitor;

   localparam int YMIN = 2;
   localparam int YMAX = 4;
   localparam int CW   = 4;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    light_main;
   logic [2:0]    light_cross;
   logic          clr_fault;
   logic          fault;
   logic [2:0]    fault_code;
   logic [CW-1:0] main_cycles;

   always #5 clk = ~clk;

   traffic_light_monitor #(
      .YELLOW_MIN(YMIN),
      .YELLOW_MAX(YMAX),
      .CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .light_main (light_main),
      .light_cross(light_cross),
      .clr_fault  (clr_fault),
      .fault      (fault),
      .fault_code (fault_code),
      .main_cycles(main_cycles)
   );

   typedef struct {
      int fault;
      int code;
      int cycles;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: raw previous lamps and unbounded yellow run lengths.
   logic [2:0] m_prev [2];
   bit         m_primed;
   int         m_yrun [2];
   int         m_fault;
   int         m_code;
   int         m_cycles;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
   endtask

   function automatic bit onehot(input logic [2:0] l);
      return $countones(l) == 1;
   endfunction

   // Lamp that legally follows l in the R -> G -> Y -> R cycle.
   function automatic logic [2:0] next_of(input logic [2:0] l);
      case (l)
         R:       return G;
         G:       return Y;
         Y:       return R;
         default: return R;
      endcase
   endfunction

   task automatic step(input logic [2:0] m, input logic [2:0] c, input bit clr, input bit r);
      logic [2:0] cur [2];
      bit   [5:1] hit;
      int         cand;
      exp_t       e;
      @(negedge clk);
      #1;
      light_main  = m;
      light_cross = c;
      clr_fault   = clr;
      rst         = r;
      cur[0] = m;
      cur[1] = c;
      if (r) begin
         m_prev[0] = '0;
         m_prev[1] = '0;
         m_primed  = 0;
         m_yrun[0] = 0;
         m_yrun[1] = 0;
         m_fault   = 0;
         m_code    = 0;
         m_cycles  = 0;
      end else begin
         hit    = '0;
         hit[1] = !onehot(m) || !onehot(c);
         hit[2] = (m != R) && (c != R);
         for (int d = 0; d < 2; d++) begin
            if (m_primed && onehot(m_prev[d]) && onehot(cur[d])
                && cur[d] != m_prev[d] && cur[d] != next_of(m_prev[d]))
               hit[3] = 1;
`ifdef TL_MON_YELLOW_TIMING_EN
            if (m_primed && m_prev[d] == Y && cur[d] == R && m_yrun[d] < YMIN) hit[4] = 1;
            if (m_primed && m_prev[d] == Y && cur[d] == Y && m_yrun[d] == YMAX) hit[5] = 1;
`endif
         end
         cand = 0;
         for (int k = 5; k >= 1; k--) if (hit[k]) cand = k;

         for (int d = 0; d < 2; d++) begin
            if (cur[d] != Y)                     m_yrun[d] = 0;
            else if (m_primed && m_prev[d] == Y) m_yrun[d] = m_yrun[d] + 1;
            else                                 m_yrun[d] = 1;
         end
         if (m_primed && m_prev[0] == R && m == G) m_cycles = (m_cycles + 1) % (1 << CW);
         if (clr) begin
            m_fault = (cand != 0) ? 1 : 0;
            m_code  = cand;
         end else if (m_fault == 0 && cand != 0) begin
            m_fault = 1;
            m_code  = cand;
         end
         m_prev[0] = m;
         m_prev[1] = c;
         m_primed  = 1;
      end
      e.fault  = m_fault;
      e.code   = m_code;
      e.cycles = m_cycles;
      exp_q.push_back(e);
   endtask

   // Two clear pulses on a steady legal pattern leave the monitor fault-free.
   task automatic clear_to(input logic [2:0] m, input logic [2:0] c);
      step(m, c, 1, 0);
      step(m, c, 1, 0);
   endtask

   function automatic logic [2:0] rand_lamp(input logic [2:0] prev);
      int r;
      r = $urandom_range(99);
      if (r < 60) return onehot(prev) ? prev : R;
      if (r < 88) return next_of(prev);
      return 3'($urandom_range(7));
   endfunction

   // Monitor: outputs are valid every cycle, so one expectation is retired per negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fault",       int'(fault),       e.fault);
            check("fault_code",  int'(fault_code),  e.code);
            check("main_cycles", int'(main_cycles), e.cycles);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] gm;
      logic [2:0] gc;
      rst         = 1'b1;
      clr_fault   = 1'b0;
      light_main  = R;
      light_cross = R;

      // Reset, then a clean main cycle handing over to the cross road and back.
      step(R, R, 0, 1);
      repeat (3) step(G, R, 0, 0);
      repeat (3) step(Y, R, 0, 0);
      step(R, R, 0, 0);
      repeat (2) step(R, G, 0, 0);
      repeat (2) step(R, Y, 0, 0);
      step(R, R, 0, 0);
      repeat (2) step(G, R, 0, 0);

      // Non-one-hot main lamp for one sample; fault stays after recovery.
      step(3'b011, R, 0, 0);
      repeat (3) step(G, R, 0, 0);
      clear_to(G, R);

      // Conflict together with an illegal main Y->G: conflict code wins.
      step(G, G, 0, 0);
      clear_to(R, R);
      step(G, R, 0, 0);
      step(Y, R, 0, 0);
      step(G, G, 0, 0);

      // Yellow too short.
      clear_to(G, R);
      step(Y, R, 0, 0);
      step(R, R, 0, 0);
      step(R, R, 0, 0);

      // Yellow too long, then a clear mid-interval must not re-flag.
      clear_to(G, R);
      repeat (5) step(Y, R, 0, 0);
      step(Y, R, 0, 0);
      step(Y, R, 1, 0);
      repeat (2) step(Y, R, 0, 0);
      step(R, R, 0, 0);

      // Counter wrap, then reset in the middle of a yellow interval.
      step(R, R, 0, 1);
      repeat (1 << CW) begin
         step(R, R, 0, 0);
         step(G, R, 0, 0);
      end
      step(G, R, 0, 0);
      repeat (2) step(Y, R, 0, 0);
      step(Y, R, 0, 1);
      step(Y, R, 0, 0);
      step(R, R, 0, 0);

      // Random walks around the legal sequence with occasional corruption.
      gm = R;
      gc = R;
      repeat (400) begin
         gm = rand_lamp(gm);
         gc = rand_lamp(gc);
         step(gm, gc, ($urandom_range(9) == 0), ($urandom_range(49) == 0));
      end

      step(R, R, 0, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
